syncs_stim: RTL and testbench

- Initiator-side counterpart of the sequence-triggered responder in chapter 4 of the SVA examples.
- Drives the handshake the responder waits on: a pulse on `a`, then a pulse on `b` exactly GAP cycles later, then a level on `d`.
- After each step it waits for the responder's toggle acknowledgements (`e` after the a/b pair, `f` after `d`).
- Runs a programmable number of transactions, counts completions, and flags a timeout when an acknowledgement never arrives.

---
 rtl/syncs_pkg.sv | 28 ++
 rtl/syncs_ack_det.sv | 27 ++
 rtl/syncs_stim.sv | 143 ++++++++++++++
 tb/tb_syncs_stim.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/syncs_pkg.sv
// syncs_pkg: shared types and widths for the syncs_stim handshake initiator.
//   stim_state_e : initiator state encoding
//   DEF_TIMEOUT  : default acknowledgement timeout in cycles
//   TO_W         : timeout counter width for the default timeout
//   to_width()   : timeout counter width for an arbitrary timeout
package syncs_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DRV_A,
        GAP,
        DRV_B,
        WAIT_E,
        DRV_D,
        WAIT_F,
        FIN,
        ERR
    } stim_state_e;

    localparam int DEF_TIMEOUT = 16;

    function automatic int to_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int TO_W = $clog2(DEF_TIMEOUT + 1);

endpackage

// File: rtl/syncs_ack_det.sv
// syncs_ack_det: toggle-edge detector for a responder acknowledgement.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   tog_in    : toggling acknowledgement from the responder
//   pulse_out : high in any cycle where tog_in differs from its last sampled value
module syncs_ack_det (
    input  logic clk,
    input  logic rst,
    input  logic tog_in,
    output logic pulse_out
);

    logic tog_q;

    // Reset captures the live input, so a toggle that happens while reset is
    // held is absorbed and never shows up as an edge after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            tog_q <= tog_in;
        end else begin
            tog_q <= tog_in;
        end
    end

    assign pulse_out = tog_in ^ tog_q;

endmodule

// File: rtl/syncs_stim.sv
// syncs_stim: initiator for the sequence-triggered responder handshake.
// Each transaction pulses a, pulses b GAP cycles later, waits for an e toggle,
// raises d, then waits for an f toggle. Runs num_txn transactions per start.
//   clk, rst  : clock and synchronous active-high reset
//   start     : begin a run (accepted only in IDLE or ERR)
//   num_txn   : transactions to run, captured on an accepted start
//   e_in,f_in : responder toggle acknowledgements
//   a, b, d   : handshake outputs
//   busy      : high outside IDLE and ERR
//   done      : one-cycle pulse at the end of a run
//   err       : sticky timeout flag, cleared by the next accepted start
//   txn_count : transactions completed in the current run
module syncs_stim
    import syncs_pkg::*;
#(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_txn,
    input  logic             e_in,
    input  logic             f_in,
    output logic             a,
    output logic             b,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] txn_count
);

    localparam int TMR_W = (TIMEOUT == DEF_TIMEOUT) ? TO_W : to_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]       GAP_LAST = 4'((GAP > 1) ? GAP - 2 : 0);

    stim_state_e      state, state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [3:0]       gcnt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cnt_inc;
    logic             e_ack, f_ack;
    logic             start_ok, inc;

    syncs_ack_det u_e_det (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (e_in),
        .pulse_out (e_ack)
    );

    syncs_ack_det u_f_det (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (f_in),
        .pulse_out (f_ack)
    );

    assign cnt_inc = txn_count + CNT_W'(1);

    // The enum literal GAP is shadowed by the parameter of the same name,
    // so the state is always referenced through the package scope.
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        inc       = 1'b0;
        case (state)
            IDLE, ERR: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = (num_txn == '0) ? FIN : DRV_A;
                end
            end
            DRV_A:         state_nxt = (GAP == 1) ? DRV_B : syncs_pkg::GAP;
            syncs_pkg::GAP: if (gcnt == GAP_LAST) state_nxt = DRV_B;
            DRV_B:         state_nxt = WAIT_E;
            WAIT_E: begin
                // An ack in the final timeout cycle still wins.
                if (e_ack)               state_nxt = DRV_D;
                else if (tmr == TO_LAST) state_nxt = ERR;
            end
            DRV_D:         state_nxt = WAIT_F;
            WAIT_F: begin
                if (f_ack) begin
                    inc       = 1'b1;
                    state_nxt = (cnt_inc == target) ? FIN : DRV_A;
                end else if (tmr == TO_LAST) begin
                    state_nxt = ERR;
                end
            end
            FIN:           state_nxt = IDLE;
            default:       state_nxt = IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a         <= 1'b0;
            b         <= 1'b0;
            d         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            txn_count <= '0;
            target    <= '0;
            tmr       <= '0;
            gcnt      <= '0;
        end else begin
            state <= state_nxt;
            a     <= (state_nxt == DRV_A);
            b     <= (state_nxt == DRV_B);
            d     <= (state_nxt == DRV_D) || (state_nxt == WAIT_F);
            busy  <= (state_nxt != IDLE) && (state_nxt != ERR);
            done  <= (state_nxt == FIN);
            err   <= (state_nxt == ERR);

            if (start_ok) begin
                target    <= num_txn;
                txn_count <= '0;
            end else if (inc) begin
                txn_count <= cnt_inc;
            end

            // Counters run only while staying in their state, so every
            // entry starts them from zero.
            if (((state == WAIT_E) || (state == WAIT_F)) && (state_nxt == state))
                tmr <= tmr + TMR_W'(1);
            else
                tmr <= '0;

            if ((state == syncs_pkg::GAP) && (state_nxt == syncs_pkg::GAP))
                gcnt <= gcnt + 4'd1;
            else
                gcnt <= '0;
        end
    end

endmodule

// File: tb/tb_syncs_stim.sv
// tb_syncs_stim: directed self-checking bench for syncs_stim (GAP=2, TIMEOUT=16).
module tb_syncs_stim;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_txn;
    logic       e_in, f_in;
    logic       a, b, d, busy, done, err;
    logic [7:0] txn_count;

    int compared   = 0;
    int mismatched = 0;

    syncs_stim #(.GAP(2), .TIMEOUT(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_txn   (num_txn),
        .e_in      (e_in),
        .f_in      (f_in),
        .a         (a),
        .b         (b),
        .d         (d),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; afterwards the DUT is in its first run state.
    task automatic kick(input logic [7:0] n);
        start   = 1'b1;
        num_txn = n;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        compared++; if ({a, b, d} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_abd: got %b want 000", {a, b, d}); end
        compared++; if ({busy, done, err} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b want 000", {busy, done, err}); end
        compared++; if (txn_count !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", txn_count); end
        rst = 1'b0;
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        kick(8'd1);
        compared++; if ({a, b, d, busy} !== 4'b1001) begin mismatched++; $display("[TB] FAIL single_drv_a: got %b want 1001", {a, b, d, busy}); end
        tick();
        compared++; if ({a, b} !== 2'b00) begin mismatched++; $display("[TB] FAIL single_gap: got %b want 00", {a, b}); end
        tick();
        compared++; if ({a, b} !== 2'b01) begin mismatched++; $display("[TB] FAIL single_drv_b: got %b want 01", {a, b}); end
        tick();
        compared++; if ({b, d} !== 2'b00) begin mismatched++; $display("[TB] FAIL single_wait_e: got %b want 00", {b, d}); end
        e_in = ~e_in;
        tick();
        compared++; if (d !== 1'b1) begin mismatched++; $display("[TB] FAIL single_drv_d: got %b want 1", d); end
        tick();
        compared++; if (d !== 1'b1) begin mismatched++; $display("[TB] FAIL single_wait_f_d: got %b want 1", d); end
        f_in = ~f_in;
        tick();
        compared++; if ({done, d} !== 2'b10) begin mismatched++; $display("[TB] FAIL single_fin: got %b want 10", {done, d}); end
        compared++; if (txn_count !== 8'd1) begin mismatched++; $display("[TB] FAIL single_count: got %0d want 1", txn_count); end
        tick();
        compared++; if ({done, busy, err} !== 3'b000) begin mismatched++; $display("[TB] FAIL single_idle: got %b want 000", {done, busy, err}); end
        compared++; if (txn_count !== 8'd1) begin mismatched++; $display("[TB] FAIL single_count_hold: got %0d want 1", txn_count); end
    endtask

    task automatic test_back_to_back();
        kick(8'd3);
        for (int i = 0; i < 3; i++) begin
            compared++; if (a !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_a%0d: got %b want 1", i, a); end
            tick();
            tick();
            compared++; if (b !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_b%0d: got %b want 1", i, b); end
            tick();
            e_in = ~e_in;
            tick();
            compared++; if (d !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_d%0d: got %b want 1", i, d); end
            tick();
            f_in = ~f_in;
            tick();
            compared++; if (txn_count !== 8'(i + 1)) begin mismatched++; $display("[TB] FAIL b2b_count%0d: got %0d want %0d", i, txn_count, i + 1); end
            compared++; if (done !== (i == 2)) begin mismatched++; $display("[TB] FAIL b2b_done%0d: got %b want %b", i, done, (i == 2)); end
        end
        tick();
        compared++; if ({done, busy} !== 2'b00) begin mismatched++; $display("[TB] FAIL b2b_end: got %b want 00", {done, busy}); end
    endtask

    task automatic test_timeout();
        kick(8'd1);
        repeat (3) tick();
        repeat (15) tick();
        compared++; if ({err, busy} !== 2'b01) begin mismatched++; $display("[TB] FAIL to_before: got %b want 01", {err, busy}); end
        tick();
        compared++; if ({err, busy} !== 2'b10) begin mismatched++; $display("[TB] FAIL to_err: got %b want 10", {err, busy}); end
        compared++; if ({a, b, d} !== 3'b000) begin mismatched++; $display("[TB] FAIL to_abd: got %b want 000", {a, b, d}); end
        repeat (3) tick();
        compared++; if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL to_sticky: got %b want 1", err); end
        kick(8'd1);
        compared++; if ({err, a, busy} !== 3'b011) begin mismatched++; $display("[TB] FAIL to_restart: got %b want 011", {err, a, busy}); end
        repeat (3) tick();
        e_in = ~e_in;
        repeat (2) tick();
        f_in = ~f_in;
        tick();
        compared++; if ({done, err} !== 2'b10) begin mismatched++; $display("[TB] FAIL to_recover_done: got %b want 10", {done, err}); end
        compared++; if (txn_count !== 8'd1) begin mismatched++; $display("[TB] FAIL to_recover_count: got %0d want 1", txn_count); end
        tick();
    endtask

    task automatic test_ack_at_timeout();
        kick(8'd1);
        repeat (3) tick();
        repeat (15) tick();
        e_in = ~e_in;
        tick();
        compared++; if ({d, err} !== 2'b10) begin mismatched++; $display("[TB] FAIL late_ack_d: got %b want 10", {d, err}); end
        tick();
        f_in = ~f_in;
        tick();
        compared++; if ({done, err} !== 2'b10) begin mismatched++; $display("[TB] FAIL late_ack_done: got %b want 10", {done, err}); end
        tick();
    endtask

    task automatic test_zero_txn();
        kick(8'd0);
        compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_done: got %b want 1", done); end
        compared++; if ({a, b, d} !== 3'b000) begin mismatched++; $display("[TB] FAIL zero_abd: got %b want 000", {a, b, d}); end
        compared++; if (txn_count !== 8'd0) begin mismatched++; $display("[TB] FAIL zero_count: got %0d want 0", txn_count); end
        tick();
        compared++; if ({done, busy} !== 2'b00) begin mismatched++; $display("[TB] FAIL zero_after: got %b want 00", {done, busy}); end
    endtask

    task automatic test_reset_mid_run();
        kick(8'd3);
        for (int i = 0; i < 3; i++) begin
            repeat (3) tick();
            e_in = ~e_in;
            repeat (2) tick();
            if (i < 2) begin
                f_in = ~f_in;
                tick();
            end
        end
        compared++; if ({d, txn_count} !== {1'b1, 8'd2}) begin mismatched++; $display("[TB] FAIL mid_pre: got d=%b cnt=%0d want d=1 cnt=2", d, txn_count); end
        rst  = 1'b1;
        f_in = ~f_in;
        e_in = ~e_in;
        tick();
        compared++; if ({a, b, d, busy, done, err} !== 6'b0) begin mismatched++; $display("[TB] FAIL mid_rst_out: got %b want 000000", {a, b, d, busy, done, err}); end
        compared++; if (txn_count !== 8'd0) begin mismatched++; $display("[TB] FAIL mid_rst_count: got %0d want 0", txn_count); end
        rst = 1'b0;
        tick();
        compared++; if ({busy, done, d} !== 3'b000) begin mismatched++; $display("[TB] FAIL mid_release: got %b want 000", {busy, done, d}); end
        kick(8'd1);
        repeat (3) tick();
        compared++; if (d !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_no_stale_ack: got %b want 0", d); end
        e_in = ~e_in;
        repeat (2) tick();
        f_in = ~f_in;
        tick();
        compared++; if ({done, txn_count} !== {1'b1, 8'd1}) begin mismatched++; $display("[TB] FAIL mid_rerun: got done=%b cnt=%0d want done=1 cnt=1", done, txn_count); end
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        num_txn = 8'd0;
        e_in    = 1'b0;
        f_in    = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_ack_at_timeout();
        test_zero_txn();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
